// File: rtl/memory_unit.sv
// Memory-stage pipeline register pair (M and W) with data-memory request/ready
// handshake; stalls upstream and inserts W-stage bubbles while an access waits.
module memory_unit #(
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_in,
   input  logic [6:0]  opcode_in,
   input  logic        branch_in,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_wr,
   output logic        stall_mem,
   output logic [3:0]  rn_memory,
   output logic [3:0]  rd_memory,
   output logic [6:0]  opcode_memory,
   output logic [1:0]  sel_w_addr1_memory,
   output logic [3:0]  rt_memory_wait,
   output logic [6:0]  opcode_memory_wait,
   output logic [31:0] instr_output,
   output logic        mem_timeout
);

   localparam logic [6:0]  NOP_OP    = 7'b0100000;
   localparam logic [31:0] NOP_INSTR = 32'h0;
   localparam int unsigned CNT_W     = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [31:0]      m_instr_q, m_instr_d;
   logic [6:0]       m_opcode_q, m_opcode_d;
   // Only rt of the wait-stage instruction is ever observed, so only it is kept.
   logic [3:0]       w_rt_q, w_rt_d;
   logic [6:0]       w_opcode_q, w_opcode_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;

   logic m_is_ldr, m_is_ldr_lit, m_is_str, m_mem_op, m_is_alu;

   always_comb begin
      m_is_ldr     = (m_opcode_q[6:4] == 3'b110);
      m_is_ldr_lit = (m_opcode_q[6:3] == 4'b1000);
      m_is_str     = (m_opcode_q[6:4] == 3'b111);
      m_mem_op     = m_is_ldr | m_is_ldr_lit | m_is_str;
      m_is_alu     = ~m_opcode_q[6] & (m_opcode_q != NOP_OP);

      mem_req   = m_mem_op;
      mem_wr    = m_is_str;
      stall_mem = m_mem_op & ~mem_ready;

      // instr[24] is P, instr[21] is W: post-indexed or write-back updates the base.
      sel_w_addr1_memory = 2'b00;
      if (m_mem_op && (!m_instr_q[24] || m_instr_q[21])) begin
         sel_w_addr1_memory = 2'b10;
      end else if (m_is_alu) begin
         sel_w_addr1_memory = 2'b01;
      end

      rn_memory          = m_instr_q[19:16];
      rd_memory          = m_instr_q[15:12];
      opcode_memory      = m_opcode_q;
      instr_output       = m_instr_q;
      rt_memory_wait     = w_rt_q;
      opcode_memory_wait = w_opcode_q;
      mem_timeout        = timeout_q;
   end

   always_comb begin
      state_d    = state_q;
      m_instr_d  = m_instr_q;
      m_opcode_d = m_opcode_q;
      w_rt_d     = w_rt_q;
      w_opcode_d = w_opcode_q;
      wait_cnt_d = wait_cnt_q;

      if (!stall_mem) begin
         m_instr_d  = branch_in ? NOP_INSTR : instr_in;
         m_opcode_d = branch_in ? NOP_OP : opcode_in;
         w_rt_d     = m_instr_q[15:12];
         w_opcode_d = m_opcode_q;
         wait_cnt_d = '0;
      end else begin
         w_rt_d     = NOP_INSTR[15:12];
         w_opcode_d = NOP_OP;
         if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
         end
      end

      timeout_d = timeout_q | (wait_cnt_d == CNT_MAX);

      case (state_q)
         IDLE:    if (stall_mem) state_d = BUSY;
         BUSY:    if (mem_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         m_instr_q  <= NOP_INSTR;
         m_opcode_q <= NOP_OP;
         w_rt_q     <= '0;
         w_opcode_q <= NOP_OP;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_instr_q  <= m_instr_d;
         m_opcode_q <= m_opcode_d;
         w_rt_q     <= w_rt_d;
         w_opcode_q <= w_opcode_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_memory_unit;

   localparam int unsigned MAXW = 8;
   localparam logic [6:0] NOP = 7'b0100000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_in;
   logic [6:0]  opcode_in;
   logic        branch_in;
   logic        mem_ready;
   logic        mem_req, mem_wr, stall_mem, mem_timeout;
   logic [3:0]  rn_memory, rd_memory, rt_memory_wait;
   logic [6:0]  opcode_memory, opcode_memory_wait;
   logic [1:0]  sel_w_addr1_memory;
   logic [31:0] instr_output;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [31:0] r_m_instr;
   logic [6:0]  r_m_op;
   logic [3:0]  r_w_rt;
   logic [6:0]  r_w_op;
   int          r_waited;
   bit          r_timeout;

   memory_unit #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .opcode_in(opcode_in),
      .branch_in(branch_in), .mem_ready(mem_ready), .mem_req(mem_req),
      .mem_wr(mem_wr), .stall_mem(stall_mem), .rn_memory(rn_memory),
      .rd_memory(rd_memory), .opcode_memory(opcode_memory),
      .sel_w_addr1_memory(sel_w_addr1_memory), .rt_memory_wait(rt_memory_wait),
      .opcode_memory_wait(opcode_memory_wait), .instr_output(instr_output),
      .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   function automatic bit is_mem(input logic [6:0] op);
      int v = int'(op);
      return (v / 16 == 6) || (v / 8 == 8) || (v / 16 == 7);
   endfunction

   function automatic bit is_store(input logic [6:0] op);
      return int'(op) / 16 == 7;
   endfunction

   function automatic bit is_alu(input logic [6:0] op);
      return int'(op) < 64 && op != NOP;
   endfunction

   function automatic logic [1:0] ref_sel(input logic [31:0] ins, input logic [6:0] op);
      bit pre  = ((ins >> 24) & 1) != 0;
      bit wbk  = ((ins >> 21) & 1) != 0;
      if (is_mem(op) && (!pre || wbk)) return 2'd2;
      if (is_alu(op)) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [6:0] rand_op();
      case ($urandom_range(0, 5))
         0: return 7'(96 + $urandom_range(0, 15));   // LDR
         1: return 7'(64 + $urandom_range(0, 7));    // LDR literal
         2: return 7'(112 + $urandom_range(0, 15));  // STR
         3: return 7'($urandom_range(0, 63));        // ALU (may hit NOP)
         4: return NOP;
         default: return 7'(72 + $urandom_range(0, 23)); // other, non-mem non-ALU
      endcase
   endfunction

   // Advance the model by one clock using the currently driven inputs.
   task automatic model_step();
      if (rst) begin
         r_m_instr = 32'h0; r_m_op = NOP; r_w_rt = 4'h0; r_w_op = NOP;
         r_waited = 0; r_timeout = 0;
      end else if (is_mem(r_m_op) && !mem_ready) begin
         r_w_rt = 4'h0; r_w_op = NOP;
         r_waited++;
         if (r_waited >= int'(MAXW)) r_timeout = 1;
      end else begin
         r_w_rt = r_m_instr[15:12]; r_w_op = r_m_op;
         r_waited = 0;
         r_m_instr = branch_in ? 32'h0 : instr_in;
         r_m_op    = branch_in ? NOP : opcode_in;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic [6:0] o, input logic b, input logic r);
      rst = 1'b0; instr_in = i; opcode_in = o; branch_in = b; mem_ready = r;
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; instr_in = 32'h0; opcode_in = NOP; branch_in = 1'b0; mem_ready = 1'b0;
      tick();
      drive(32'h0, NOP, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      drive(32'h0123_9000, 7'b1100000, 1'b0, 1'b0);
      tick();
      drive(32'hDEAD_BEEF, 7'b0011000, 1'b0, 1'b0);
      tick();  // now waiting on the load
      rst = 1'b1;
      tick();
      tick();
      drive(32'hFFFF_FFFF, 7'b1110000, 1'b0, 1'b0);
      n_cmp++; if (opcode_memory !== NOP) begin n_bad++; $display("FAIL rst_op_m got %b exp %b", opcode_memory, NOP); end
      n_cmp++; if (opcode_memory_wait !== NOP) begin n_bad++; $display("FAIL rst_op_w got %b exp %b", opcode_memory_wait, NOP); end
      n_cmp++; if (mem_req !== 1'b0 || mem_wr !== 1'b0 || stall_mem !== 1'b0) begin n_bad++; $display("FAIL rst_ctl got req%b wr%b st%b exp 000", mem_req, mem_wr, stall_mem); end
      n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_to got %b exp 0", mem_timeout); end
      n_cmp++; if ({rn_memory, rd_memory, rt_memory_wait, sel_w_addr1_memory} !== 14'h0) begin n_bad++; $display("FAIL rst_fields got %h exp 0", {rn_memory, rd_memory, rt_memory_wait, sel_w_addr1_memory}); end
      n_cmp++; if (instr_output !== 32'h0) begin n_bad++; $display("FAIL rst_instr got %h exp 0", instr_output); end
   endtask

   task automatic test_alu();
      apply_reset();
      drive(32'hE0A2_5ABC, 7'b0011000, 1'b0, 1'b0);
      tick();
      drive(32'h0, NOP, 1'b0, 1'b0);
      n_cmp++; if (rn_memory !== 4'd2 || rd_memory !== 4'd5) begin n_bad++; $display("FAIL alu_regs got rn%0d rd%0d exp rn2 rd5", rn_memory, rd_memory); end
      n_cmp++; if (sel_w_addr1_memory !== 2'b01) begin n_bad++; $display("FAIL alu_sel got %b exp 01", sel_w_addr1_memory); end
      n_cmp++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin n_bad++; $display("FAIL alu_req got req%b st%b exp 00", mem_req, stall_mem); end
      tick();
      n_cmp++; if (opcode_memory_wait !== 7'b0011000 || rt_memory_wait !== 4'd5) begin n_bad++; $display("FAIL alu_wait got op%b rt%0d exp op0011000 rt5", opcode_memory_wait, rt_memory_wait); end
   endtask

   task automatic test_ldr_wait();
      apply_reset();
      drive(32'h0123_9000, 7'b1100000, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(32'h0007_8000, 7'b0000101, 1'b0, 1'b0);
         n_cmp++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || stall_mem !== 1'b1) begin n_bad++; $display("FAIL ldr_stall%0d got req%b wr%b st%b exp 101", k, mem_req, mem_wr, stall_mem); end
         n_cmp++; if (sel_w_addr1_memory !== 2'b10) begin n_bad++; $display("FAIL ldr_sel%0d got %b exp 10", k, sel_w_addr1_memory); end
         n_cmp++; if (instr_output !== 32'h0123_9000 || opcode_memory !== 7'b1100000) begin n_bad++; $display("FAIL ldr_hold%0d got %h/%b exp 01239000/1100000", k, instr_output, opcode_memory); end
         if (k > 0) begin
            n_cmp++; if (opcode_memory_wait !== NOP) begin n_bad++; $display("FAIL ldr_bubble%0d got %b exp %b", k, opcode_memory_wait, NOP); end
         end
         tick();
      end
      drive(32'h0007_8000, 7'b0000101, 1'b0, 1'b1);
      n_cmp++; if (mem_req !== 1'b1 || stall_mem !== 1'b0) begin n_bad++; $display("FAIL ldr_done got req%b st%b exp 10", mem_req, stall_mem); end
      n_cmp++; if (opcode_memory_wait !== NOP) begin n_bad++; $display("FAIL ldr_bubble3 got %b exp %b", opcode_memory_wait, NOP); end
      tick();
      drive(32'h0, NOP, 1'b0, 1'b0);
      n_cmp++; if (opcode_memory_wait !== 7'b1100000 || rt_memory_wait !== 4'd9) begin n_bad++; $display("FAIL ldr_wb got op%b rt%0d exp op1100000 rt9", opcode_memory_wait, rt_memory_wait); end
      n_cmp++; if (opcode_memory !== 7'b0000101 || mem_req !== 1'b0) begin n_bad++; $display("FAIL ldr_next got op%b req%b exp op0000101 req0", opcode_memory, mem_req); end
   endtask

   task automatic test_str();
      apply_reset();
      drive(32'h0104_7000, 7'b1110000, 1'b0, 1'b1);
      tick();
      drive(32'h0, NOP, 1'b0, 1'b1);
      n_cmp++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || stall_mem !== 1'b0) begin n_bad++; $display("FAIL str_ctl got req%b wr%b st%b exp 110", mem_req, mem_wr, stall_mem); end
      n_cmp++; if (sel_w_addr1_memory !== 2'b00) begin n_bad++; $display("FAIL str_sel got %b exp 00", sel_w_addr1_memory); end
      tick();
      n_cmp++; if (mem_wr !== 1'b0 || opcode_memory_wait !== 7'b1110000 || rt_memory_wait !== 4'd7) begin n_bad++; $display("FAIL str_after got wr%b op%b rt%0d exp wr0 op1110000 rt7", mem_wr, opcode_memory_wait, rt_memory_wait); end
   endtask

   task automatic test_branch();
      apply_reset();
      drive(32'h0125_6000, 7'b1100010, 1'b1, 1'b0);
      tick();
      drive(32'h0, NOP, 1'b0, 1'b0);
      n_cmp++; if (opcode_memory !== NOP || instr_output !== 32'h0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL br_flush got op%b ins%h req%b exp NOP/0/0", opcode_memory, instr_output, mem_req); end
      drive(32'h0033_4000, 7'b1000001, 1'b0, 1'b0);
      tick();
      drive(32'hAAAA_5555, 7'b0010001, 1'b1, 1'b0);
      tick();
      drive(32'hAAAA_5555, 7'b0010001, 1'b0, 1'b0);
      n_cmp++; if (opcode_memory !== 7'b1000001 || instr_output !== 32'h0033_4000 || stall_mem !== 1'b1) begin n_bad++; $display("FAIL br_stall got op%b ins%h st%b exp 1000001/00334000/1", opcode_memory, instr_output, stall_mem); end
      drive(32'h0001_2000, 7'b0010001, 1'b0, 1'b1);
      tick();
      drive(32'h0, NOP, 1'b0, 1'b0);
      n_cmp++; if (opcode_memory !== 7'b0010001 || instr_output !== 32'h0001_2000) begin n_bad++; $display("FAIL br_resume got op%b ins%h exp 0010001/00012000", opcode_memory, instr_output); end
   endtask

   task automatic test_timeout();
      apply_reset();
      drive(32'h0123_9000, 7'b1100000, 1'b0, 1'b0);
      tick();
      for (int k = 1; k <= 10; k++) begin
         drive(32'h0, NOP, 1'b0, 1'b0);
         n_cmp++; if (mem_timeout !== (k >= 9) || stall_mem !== 1'b1) begin n_bad++; $display("FAIL to_cyc%0d got to%b st%b exp to%b st1", k, mem_timeout, stall_mem, k >= 9); end
         tick();
      end
      drive(32'h0, NOP, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(32'h0, NOP, 1'b0, 1'($urandom_range(0, 1)));
         n_cmp++; if (mem_timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky%0d got %b exp 1", k, mem_timeout); end
         tick();
      end
      apply_reset();
      n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("FAIL to_clear got %b exp 0", mem_timeout); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 500; c++) begin
         drive($urandom, rand_op(), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) < 6));
         if ($urandom_range(0, 99) == 0) rst = 1'b1;
         else begin
            n_cmp++; if (opcode_memory !== r_m_op || instr_output !== r_m_instr) begin n_bad++; $display("FAIL rnd_m c%0d got %b/%h exp %b/%h", c, opcode_memory, instr_output, r_m_op, r_m_instr); end
            n_cmp++; if (rn_memory !== r_m_instr[19:16] || rd_memory !== r_m_instr[15:12]) begin n_bad++; $display("FAIL rnd_regs c%0d got %h/%h exp %h/%h", c, rn_memory, rd_memory, r_m_instr[19:16], r_m_instr[15:12]); end
            n_cmp++; if (sel_w_addr1_memory !== ref_sel(r_m_instr, r_m_op)) begin n_bad++; $display("FAIL rnd_sel c%0d got %b exp %b", c, sel_w_addr1_memory, ref_sel(r_m_instr, r_m_op)); end
            n_cmp++; if (mem_req !== is_mem(r_m_op) || mem_wr !== is_store(r_m_op) || stall_mem !== (is_mem(r_m_op) && !mem_ready)) begin n_bad++; $display("FAIL rnd_ctl c%0d got %b%b%b exp %b%b%b", c, mem_req, mem_wr, stall_mem, is_mem(r_m_op), is_store(r_m_op), is_mem(r_m_op) && !mem_ready); end
            n_cmp++; if (opcode_memory_wait !== r_w_op || rt_memory_wait !== r_w_rt) begin n_bad++; $display("FAIL rnd_w c%0d got %b/%h exp %b/%h", c, opcode_memory_wait, rt_memory_wait, r_w_op, r_w_rt); end
            n_cmp++; if (mem_timeout !== r_timeout) begin n_bad++; $display("FAIL rnd_to c%0d got %b exp %b", c, mem_timeout, r_timeout); end
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; instr_in = 32'h0; opcode_in = NOP; branch_in = 1'b0; mem_ready = 1'b0;
      r_m_instr = 32'h0; r_m_op = NOP; r_w_rt = 4'h0; r_w_op = NOP; r_waited = 0; r_timeout = 0;
      tick();
      tick();
      test_reset();
      test_alu();
      test_ldr_wait();
      test_str();
      test_branch();
      test_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/memory_unit.md
# memory_unit

Memory-stage pipeline unit and controller, the producer side of the execute stage's forwarding and stall interface. It registers the instruction leaving execute and publishes the memory-stage and wait-stage fields the execute controller compares against: rn/rd/opcode/write-back select, and rt/opcode one stage later. It also runs the data-memory request/ready handshake, and stalls upstream while a load or store is outstanding.

## Interface
Parameters:
- MAX_WAIT, 8: wait-cycle count at which the sticky mem_timeout flag sets.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- instr_in  in  32  instruction from the execute stage.
- opcode_in  in  7  decoded opcode from the execute stage.
- branch_in  in  1  flush; when set, a NOP is loaded instead of instr_in.
- mem_ready  in  1  data memory has completed the current access.
- mem_req  out  1  data-memory access request.
- mem_wr  out  1  access is a store; valid while mem_req is high.
- stall_mem  out  1  hold upstream stages; drives the execute stage's sel_stall.
- rn_memory  out  4  M.instr[19:16].
- rd_memory  out  4  M.instr[15:12].
- opcode_memory  out  7  M.opcode.
- sel_w_addr1_memory  out  2  write-back select for the M stage instruction.
- rt_memory_wait  out  4  W.instr[15:12].
- opcode_memory_wait  out  7  W.opcode.
- instr_output  out  32  M.instr, passed to the wait stage datapath.
- mem_timeout  out  1  sticky; set when an access has waited MAX_WAIT cycles.

## Operation
- NOP is opcode 7'b0100000 with instr 32'h0.
- Opcode classes:
  - LDR: opcode[6:4]==3'b110.
  - LDR_Lit: opcode[6:3]==4'b1000.
  - STR: opcode[6:4]==3'b111.
  - mem_op = LDR, LDR_Lit or STR.
  - ALU: opcode[6]==0 and not NOP.
- Registers:
  - M stage: {instr, opcode}.
  - W stage: {instr, opcode}.
  - FSM: IDLE or BUSY.
  - wait_cnt: width $clog2(MAX_WAIT+1), saturating.
- sel_w_addr1_memory, combinational from M (the two bits are instr[24] and instr[21]):
  - 2'b10 if mem_op and (P==0 or W==1), i.e. base write-back.
  - else 2'b01 if ALU, i.e. rd write-back.
  - else 2'b00.
- mem_req = M.mem_op. mem_wr = M is STR.
- stall_mem = mem_req and !mem_ready, combinational.
- An access completes in the cycle mem_req and mem_ready are both high.
- FSM:
  - IDLE -> BUSY when mem_req and !mem_ready.
  - BUSY -> IDLE on mem_ready.
  - BUSY holds otherwise.
  - IDLE is the only state in which M may have been loaded this cycle.
- M update:
  - If !stall_mem: M <= branch_in ? NOP : {instr_in, opcode_in}.
  - If stall_mem: M holds.
- W update:
  - If !stall_mem: W <= M.
  - If stall_mem: W <= NOP, a bubble.
- wait_cnt:
  - Cleared when not stalling.
  - Increments each stall cycle, saturating at MAX_WAIT.
  - mem_timeout sets when wait_cnt reaches MAX_WAIT; cleared only by rst.
- branch_in is sampled only on cycles with !stall_mem. Upstream holds it during a stall.
- M.mem_op with M==NOP is impossible by encoding, so a NOP never requests memory.

## Timing
- Reset, applied at the clock edge where rst is high:
  - M and W = NOP, FSM = IDLE, wait_cnt = 0, mem_timeout = 0.
  - Hence mem_req = 0, mem_wr = 0, stall_mem = 0, sel_w_addr1_memory = 2'b00.
  - rn/rd/rt outputs = 0. opcode_memory and opcode_memory_wait = 7'b0100000.
- rst during BUSY aborts the access. mem_req is low from the first cycle after the reset edge.
- Latency:
  - instr_in appears on M outputs one cycle after it is presented.
  - M moves to W on the edge ending the completing cycle.
- Zero-wait memory (mem_ready high with mem_req): no stall, one instruction per cycle.
- N-cycle wait:
  - stall_mem is high for exactly N cycles.
  - N NOP bubbles enter W.
  - The load/store enters W on the edge of the cycle mem_ready rises.
- Back-to-back memory ops each handshake independently. mem_req stays high across the boundary.
- mem_ready while mem_req is low is ignored.

## Test plan
- Reset: hold rst 2 cycles mid-stream -> opcode_memory = opcode_memory_wait = 7'b0100000, mem_req = 0, stall_mem = 0, mem_timeout = 0.
- ALU op: opcode_in = 7'b0011000, instr[19:16] = 2, instr[15:12] = 5, no memory -> next cycle rn_memory = 2, rd_memory = 5, sel_w_addr1_memory = 2'b01; the following cycle opcode_memory_wait = 7'b0011000.
- LDR, pre-indexed with W=1, mem_ready low 3 cycles: mem_req high 4 cycles, mem_wr = 0, sel_w_addr1_memory = 2'b10, stall_mem high 3 cycles, M held, W shows 3 NOPs then the LDR with rt_memory_wait = instr[15:12].
- STR with P=1, W=0 and mem_ready tied high: mem_wr = 1 for 1 cycle, no stall, sel_w_addr1_memory = 2'b00.
- branch_in high with a valid instr_in -> M becomes NOP and mem_req stays 0. Second stimulus: branch_in high during a stall -> ignored, the held instruction is kept.
- Timeout: MAX_WAIT = 8, mem_ready held low 10 cycles -> mem_timeout rises after the 8th stall cycle and stays high after completion, until rst.
